// File: rtl/page_sub_pkg.sv
// Shared leaf-packet definitions for the page subdivide splitter.
package page_sub_pkg;

  localparam int unsigned PKT_W     = 49;
  localparam int unsigned VALID_BIT = PKT_W - 1;
  localparam int unsigned SEL_LSB   = 43;
  // Widest child-select field supported (up to 8 children).
  localparam int unsigned MAX_SEL_W = 3;

  typedef logic [PKT_W-1:0] leaf_pkt_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_SEND
  } arb_state_t;

  // Returns the widest possible child-select field; callers truncate to their own width.
  function automatic logic [MAX_SEL_W-1:0] pkt_sel(input leaf_pkt_t pkt,
                                                   input int unsigned lsb = SEL_LSB);
    return MAX_SEL_W'(pkt >> lsb);
  endfunction

endpackage

// File: rtl/page_sub_fifo.sv
// Per-child up-path FIFO: power-of-2 depth, simultaneous push/pop allowed even when full.
// afull is registered from the post-edge occupancy (free slots <= 1).
module page_sub_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 49
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             afull
);
  import page_sub_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign pop_data = mem[rd_ptr];

  // Occupancy after this edge.
  always_comb begin
    cnt_next = cnt;
    unique case ({do_push, do_pop})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Pointers, occupancy and almost-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      afull  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_next;
      afull <= (cnt_next >= CW'(DEPTH - 1));
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/page_subdivide_arb.sv
// N-way leaf splitter: registered down-path demux by child-select field, per-child
// up-path FIFOs merged round-robin onto the single leaf output.
// Optional statistics counters enabled by defining PAGE_SUB_STATS_EN.
module page_subdivide_arb #(
  parameter int unsigned NUM_CHILD  = 4,
  parameter int unsigned PKT_W      = page_sub_pkg::PKT_W,
  parameter int unsigned SEL_LSB    = page_sub_pkg::SEL_LSB,
  parameter int unsigned SEL_W      = $clog2(NUM_CHILD),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk_400,
  input  logic                       reset_400,
  input  logic [PKT_W-1:0]           din_leaf_bft2interface,
  output logic [PKT_W-1:0]           dout_leaf_interface2bft,
  input  logic                       resend,
  input  logic [NUM_CHILD*PKT_W-1:0] din_leaf_child2sub,
  output logic [NUM_CHILD*PKT_W-1:0] dout_leaf_sub2child,
  output logic [NUM_CHILD-1:0]       resend_child,
  output logic [15:0]                drop_cnt,
  output logic [NUM_CHILD*16-1:0]    up_cnt
);
  import page_sub_pkg::*;

  logic [NUM_CHILD-1:0] push;
  logic [NUM_CHILD-1:0] pop;
  logic [NUM_CHILD-1:0] full;
  logic [NUM_CHILD-1:0] empty;
  logic [NUM_CHILD-1:0] afull;
  logic [PKT_W-1:0]     fifo_q [NUM_CHILD];

  arb_state_t           state_q;
  logic [SEL_W-1:0]     rr_q;
  logic [SEL_W-1:0]     win_idx;
  logic [SEL_W-1:0]     cand;
  logic [SEL_W-1:0]     next_rr;
  logic                 win_found;
  logic                 grant;
  (* dont_touch = "true" *) logic [PKT_W-1:0] dout_q;

  logic [SEL_W-1:0]     sel;
  logic                 sel_ok;

  for (genvar k = 0; k < NUM_CHILD; k++) begin : g_child
    logic [PKT_W-1:0] child_pkt;
    assign child_pkt = din_leaf_child2sub[k*PKT_W +: PKT_W];
    assign push[k]   = child_pkt[PKT_W-1] && (!full[k] || pop[k]);

    page_sub_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PKT_W)
    ) u_fifo (
      .clk       (clk_400),
      .rst       (reset_400),
      .push      (push[k]),
      .push_data (child_pkt),
      .pop       (pop[k]),
      .pop_data  (fifo_q[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .afull     (afull[k])
    );
  end

  assign resend_child            = afull;
  assign dout_leaf_interface2bft = dout_q;

  // Round-robin search: first non-empty FIFO at or after the RR pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CHILD; i++) begin
      cand = SEL_W'((32'(rr_q) + i) % NUM_CHILD);
      if (!win_found && !empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign next_rr = (win_idx == SEL_W'(NUM_CHILD - 1)) ? '0 : win_idx + SEL_W'(1);
  // resend only freezes the output register while a packet is being presented.
  assign grant   = win_found && ((state_q == ARB_IDLE) || !resend);

  // One-hot pop of the current winner.
  always_comb begin
    pop = '0;
    if (grant) pop[win_idx] = 1'b1;
  end

  // Up-path arbiter with registered output packet.
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      state_q <= ARB_IDLE;
      dout_q  <= '0;
      rr_q    <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (win_found) begin
            dout_q  <= fifo_q[win_idx];
            rr_q    <= next_rr;
            state_q <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (!resend) begin
            if (win_found) begin
              dout_q <= fifo_q[win_idx];
              rr_q   <= next_rr;
            end else begin
              dout_q  <= '0;
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign sel    = SEL_W'(pkt_sel(din_leaf_bft2interface, SEL_LSB));
  assign sel_ok = ({1'b0, sel} < (SEL_W + 1)'(NUM_CHILD));

  // Down-path registered demux; only the selected child sees the packet.
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      dout_leaf_sub2child <= '0;
    end else begin
      dout_leaf_sub2child <= '0;
      if (din_leaf_bft2interface[PKT_W-1] && sel_ok)
        dout_leaf_sub2child[sel*PKT_W +: PKT_W] <= din_leaf_bft2interface;
    end
  end

`ifdef PAGE_SUB_STATS_EN
  logic        drop;
  logic [15:0] drop_q;
  logic [15:0] up_q [NUM_CHILD];

  assign drop = din_leaf_bft2interface[PKT_W-1] && !sel_ok;

  // Saturating count of down packets addressed past the last child.
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400)                  drop_q <= '0;
    else if (drop && drop_q != '1)  drop_q <= drop_q + 16'd1;
  end

  // Saturating per-child forwarded count; held re-presentations do not pop.
  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      for (int unsigned k = 0; k < NUM_CHILD; k++) up_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CHILD; k++)
        if (pop[k] && up_q[k] != '1) up_q[k] <= up_q[k] + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
  for (genvar k = 0; k < NUM_CHILD; k++) begin : g_up_cnt
    assign up_cnt[k*16 +: 16] = up_q[k];
  end
`else
  assign drop_cnt = '0;
  assign up_cnt   = '0;
`endif

endmodule

// File: tb/tb_page_subdivide_arb.sv
module tb_page_subdivide_arb;
  import page_sub_pkg::*;

  localparam int N = 4;
  localparam int W = 49;
  localparam int D = 4;
`ifdef PAGE_SUB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [W-1:0] pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]   din = '0, dout;
  logic           resend = 1'b0;
  logic [N*W-1:0] child_in = '0, sub2child;
  logic [N-1:0]   rc;
  logic [15:0]    drop_cnt;
  logic [N*16-1:0] up_cnt;

  logic [W-1:0]   din3 = '0, dout3;
  logic           resend3 = 1'b0;
  logic [3*W-1:0] child3_in = '0, sub3;
  logic [2:0]     rc3;
  logic [15:0]    drop3;
  logic [47:0]    up3;

  page_subdivide_arb #(.NUM_CHILD(4), .FIFO_DEPTH(D)) dut (
    .clk_400(clk), .reset_400(rst),
    .din_leaf_bft2interface(din), .dout_leaf_interface2bft(dout),
    .resend(resend), .din_leaf_child2sub(child_in),
    .dout_leaf_sub2child(sub2child), .resend_child(rc),
    .drop_cnt(drop_cnt), .up_cnt(up_cnt));

  page_subdivide_arb #(.NUM_CHILD(3), .FIFO_DEPTH(D)) dut3 (
    .clk_400(clk), .reset_400(rst),
    .din_leaf_bft2interface(din3), .dout_leaf_interface2bft(dout3),
    .resend(resend3), .din_leaf_child2sub(child3_in),
    .dout_leaf_sub2child(sub3), .resend_child(rc3),
    .drop_cnt(drop3), .up_cnt(up3));

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: queues per child, a busy flag and an RR index.
  pkt_t mq [N][$];
  pkt_t m_out;
  bit   m_busy;
  int   m_rr;
  pkt_t m_down [N];
  int   m_up [N];
  bit   m_rc [N];

  function automatic pkt_t rnd_pkt(bit valid, int sel);
    pkt_t p;
    p = pkt_t'({$urandom(), $urandom()});
    p[W-1] = valid;
    if (sel >= 0) p[44:43] = sel[1:0];
    return p;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      m_down[k] = '0;
      m_up[k]   = 0;
      m_rc[k]   = 1'b0;
    end
    m_out = '0; m_busy = 1'b0; m_rr = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      int   w;
      pkt_t p;
      bit   can_pop;
      for (int k = 0; k < N; k++) m_down[k] = '0;
      if (din[W-1]) m_down[din[44:43]] = din;
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && mq[(m_rr + i) % N].size() > 0) w = (m_rr + i) % N;
      can_pop = !m_busy || !resend;
      if (can_pop && w >= 0) begin
        m_out  = mq[w].pop_front();
        m_busy = 1'b1;
        m_rr   = (w + 1) % N;
        if (m_up[w] < 65535) m_up[w]++;
      end else if (m_busy && !resend) begin
        m_out  = '0;
        m_busy = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        p = child_in[k*W +: W];
        if (p[W-1] && mq[k].size() < D) mq[k].push_back(p);
      end
      for (int k = 0; k < N; k++) m_rc[k] = (D - mq[k].size()) <= 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      din = rnd_pkt(1'b1, -1);
      din3 = rnd_pkt(1'b1, 3);
      child_in = {rnd_pkt(1, -1), rnd_pkt(1, -1), rnd_pkt(1, -1), rnd_pkt(1, -1)};
      resend = 1'(c);
      @(negedge clk);
      n_checks++;
      if (dout !== '0 || dout3 !== '0) begin
        n_fail++; $display("FAIL reset_dout: got %h/%h expected 0", dout, dout3);
      end
      n_checks++;
      if (sub2child !== '0 || sub3 !== '0) begin
        n_fail++; $display("FAIL reset_sub2child: got %h expected 0", sub2child);
      end
      n_checks++;
      if (rc !== '0 || drop_cnt !== '0 || up_cnt !== '0 || rc3 !== '0 || drop3 !== '0 || up3 !== '0) begin
        n_fail++; $display("FAIL reset_misc: rc %b drop %h up %h expected 0", rc, drop_cnt, up_cnt);
      end
    end
    child_in = '0; din3 = '0; resend = 1'b0;
    clear_model();
    din = rnd_pkt(1'b1, 1);
    rst = 1'b0;
    begin
      pkt_t sent;
      logic [N*W-1:0] e;
      sent = din;
      @(negedge clk);
      din = '0;
      e = '0;
      e[1*W +: W] = sent;
      n_checks++;
      if (sub2child !== e) begin
        n_fail++; $display("FAIL reset_release_down: got %h expected %h", sub2child, e);
      end
    end
  endtask

  task automatic test_down_demux();
    pkt_t p;
    logic [N*W-1:0] e;
    p = '0; p[W-1] = 1'b1; p[44:43] = 2'd2; p[15:0] = 16'h1234;
    din = p;
    @(negedge clk);
    e = '0; e[2*W +: W] = p;
    n_checks++;
    if (sub2child !== e) begin
      n_fail++; $display("FAIL demux_sel2: got %h expected %h", sub2child, e);
    end
    for (int c = 0; c < 20; c++) begin
      din = rnd_pkt(1'($urandom_range(0, 1)), -1);
      @(negedge clk);
      for (int k = 0; k < N; k++) e[k*W +: W] = m_down[k];
      n_checks++;
      if (sub2child !== e) begin
        n_fail++; $display("FAIL demux_random: got %h expected %h", sub2child, e);
      end
    end
    din = '0;
  endtask

  task automatic test_down_drop();
    pkt_t p;
    logic [3*W-1:0] e;
    for (int c = 1; c <= 2; c++) begin
      din3 = rnd_pkt(1'b1, 3);
      @(negedge clk);
      n_checks++;
      if (sub3 !== '0) begin
        n_fail++; $display("FAIL drop_no_output: got %h expected 0", sub3);
      end
      n_checks++;
      if (drop3 !== (STATS ? 16'(c) : 16'd0)) begin
        n_fail++; $display("FAIL drop_cnt: got %0d expected %0d", drop3, STATS ? c : 0);
      end
    end
    p = rnd_pkt(1'b1, 1);
    din3 = p;
    @(negedge clk);
    din3 = '0;
    e = '0; e[1*W +: W] = p;
    n_checks++;
    if (sub3 !== e || drop3 !== (STATS ? 16'd2 : 16'd0)) begin
      n_fail++; $display("FAIL drop_then_valid: got %h cnt %0d expected %h", sub3, drop3, e);
    end
  endtask

  task automatic test_round_robin();
    pkt_t pk [N];
    resend = 1'b0;
    for (int k = 0; k < N; k++) begin
      pk[k] = rnd_pkt(1'b1, -1);
      child_in[k*W +: W] = pk[k];
    end
    @(negedge clk);
    child_in = '0;
    n_checks++;
    if (dout !== '0) begin
      n_fail++; $display("FAIL rr_latency: got %h expected 0", dout);
    end
    for (int t = 0; t < N; t++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== pk[t]) begin
        n_fail++; $display("FAIL rr_order%0d: got %h expected %h", t, dout, pk[t]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (dout !== '0) begin
      n_fail++; $display("FAIL rr_idle: got %h expected 0", dout);
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (up_cnt[k*16 +: 16] !== (STATS ? 16'd1 : 16'd0)) begin
        n_fail++; $display("FAIL rr_up_cnt%0d: got %0d expected %0d", k, up_cnt[k*16 +: 16], STATS ? 1 : 0);
      end
    end
  endtask

  task automatic test_resend();
    pkt_t a, b;
    a = rnd_pkt(1'b1, -1);
    b = rnd_pkt(1'b1, -1);
    child_in[0 +: W] = a;
    @(negedge clk);
    child_in[0 +: W] = b;
    @(negedge clk);
    child_in = '0;
    n_checks++;
    if (dout !== a) begin
      n_fail++; $display("FAIL resend_first: got %h expected %h", dout, a);
    end
    resend = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== a || up_cnt[15:0] !== (STATS ? 16'd2 : 16'd0)) begin
        n_fail++; $display("FAIL resend_hold%0d: got %h cnt %0d expected %h", c, dout, up_cnt[15:0], a);
      end
    end
    resend = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dout !== b || up_cnt[15:0] !== (STATS ? 16'd3 : 16'd0)) begin
      n_fail++; $display("FAIL resend_next: got %h cnt %0d expected %h", dout, up_cnt[15:0], b);
    end
    @(negedge clk);
    n_checks++;
    if (dout !== '0) begin
      n_fail++; $display("FAIL resend_idle: got %h expected 0", dout);
    end
  endtask

  task automatic test_throttle();
    pkt_t sent [$];
    pkt_t p;
    resend = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        n_checks++;
        if (rc[1] !== (mq[1].size() >= D - 1)) begin
          n_fail++; $display("FAIL throttle_rc: got %b expected %b at occupancy %0d", rc[1], mq[1].size() >= D - 1, mq[1].size());
        end
      end
      if (!rc[1]) begin
        p = rnd_pkt(1'b1, -1);
        sent.push_back(p);
        child_in[1*W +: W] = p;
      end else begin
        child_in = '0;
      end
      @(negedge clk);
    end
    child_in = '0;
    n_checks++;
    if (sent.size() != D || dout !== sent[0]) begin
      n_fail++; $display("FAIL throttle_held: got %h sent %0d expected %h", dout, sent.size(), sent[0]);
    end
    void'(sent.pop_front());
    resend = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dout[W-1]) begin
        n_checks++;
        if (sent.size() == 0 || dout !== sent[0]) begin
          n_fail++; $display("FAIL throttle_drain: got %h", dout);
        end
        if (sent.size() != 0) void'(sent.pop_front());
      end
    end
    n_checks++;
    if (sent.size() != 0 || dout !== '0) begin
      n_fail++; $display("FAIL throttle_lost: got %0d left expected 0", sent.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < N; k++) child_in[k*W +: W] = rnd_pkt(1'b1, -1);
    @(negedge clk);
    child_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (dout !== '0 || rc !== '0 || up_cnt !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h rc %b expected 0", dout, rc);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== '0) begin
        n_fail++; $display("FAIL reset_discard: got %h expected 0", dout);
      end
    end
  endtask

  task automatic test_random();
    logic [N*W-1:0] e;
    logic [N*16-1:0] eu;
    logic [N-1:0] erc;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        din = rnd_pkt(1'($urandom_range(0, 1)), -1);
        resend = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < N; k++)
          child_in[k*W +: W] = (!rc[k] && $urandom_range(0, 1) == 1) ? rnd_pkt(1'b1, -1) : '0;
      end else begin
        din = '0; resend = 1'b0; child_in = '0;
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        e[k*W +: W]   = m_down[k];
        eu[k*16 +: 16] = STATS ? 16'(m_up[k]) : 16'd0;
        erc[k]        = m_rc[k];
      end
      n_checks++;
      if (dout !== m_out) begin
        n_fail++; $display("FAIL rand_dout c%0d: got %h expected %h", c, dout, m_out);
      end
      n_checks++;
      if (sub2child !== e) begin
        n_fail++; $display("FAIL rand_down c%0d: got %h expected %h", c, sub2child, e);
      end
      n_checks++;
      if (rc !== erc || up_cnt !== eu) begin
        n_fail++; $display("FAIL rand_rc_up c%0d: got %b %h expected %b %h", c, rc, up_cnt, erc, eu);
      end
    end
    n_checks++;
    if (dout !== '0) begin
      n_fail++; $display("FAIL rand_drained: got %h expected 0", dout);
    end
  endtask

  initial begin
    test_reset();
    test_down_demux();
    test_down_drop();
    test_round_robin();
    test_resend();
    test_throttle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
